// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count and status flags.
// Offers registered-read (FWFT=0) or first-word-fall-through (FWFT=1) output.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_acc;
  logic             wr_acc;
  logic             empty_w;
  logic             full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_CNT);

  // A read at full frees a slot on the same edge, so a paired write is allowed.
  assign rd_acc = rd_en & ~empty_w;
  assign wr_acc = wr_en & (~full_w | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wr_en & ~wr_acc;
    underflow_d = rd_en & empty_w;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  // In FWFT mode dout_q tracks the word on display so it can be held once empty.
  always_comb begin
    dout_d = dout_q;
    if (FWFT != 0) begin
      if (!empty_w) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end else if (rd_acc) begin
      dout_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; zeroed pointers make old words unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout         = ((FWFT != 0) && !empty_w) ? mem_q[rd_ptr_q] : dout_q;
  assign empty        = empty_w;
  assign full         = full_w;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: one registered-read and one FWFT
// instance share stimulus and are compared against a queue-based scoreboard.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0] dout0, dout1;
  logic       empty0, full0, af0, ae0, ovf0, unf0;
  logic       empty1, full1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout0), .empty(empty0), .full(full0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout1), .empty(empty1), .full(full1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: words pushed on accepted writes, popped on accepted reads.
  logic [7:0] sb_q[$];
  logic [7:0] exp_d0;
  logic [7:0] exp_d1;
  logic       exp_ovf;
  logic       exp_unf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         exp_count;
    logic       exp_ovf;
    logic       exp_unf;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    rst   = 1'b1;
    sb_q.delete();
    exp_d0  = 8'h00;
    exp_d1  = 8'h00;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs and advance the scoreboard across the clock edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d);
    logic rd_ok;
    logic wr_ok;
    int   occ;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    occ     = sb_q.size();
    rd_ok   = rd && (occ != 0);
    wr_ok   = wr && ((occ != 16) || rd_ok);
    exp_ovf = wr && !wr_ok;
    exp_unf = rd && (occ == 0);
    if (occ != 0) exp_d1 = sb_q[0];
    if (rd_ok) exp_d0 = sb_q.pop_front();
    if (wr_ok) sb_q.push_back(d);
    if (sb_q.size() != 0) exp_d1 = sb_q[0];
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int occ;
    occ = sb_q.size();
    chk({tag, ".count"},  32'(count0), 32'(occ));
    chk({tag, ".empty"},  32'(empty0), 32'(occ == 0));
    chk({tag, ".full"},   32'(full0),  32'(occ == 16));
    chk({tag, ".afull"},  32'(af0),    32'(occ >= 14));
    chk({tag, ".aempty"}, 32'(ae0),    32'(occ <= 2));
    chk({tag, ".ovf"},    32'(ovf0),   32'(exp_ovf));
    chk({tag, ".unf"},    32'(unf0),   32'(exp_unf));
    chk({tag, ".dout0"},  32'(dout0),  32'(exp_d0));
    chk({tag, ".dout1"},  32'(dout1),  32'(exp_d1));
    chk({tag, ".count1"}, 32'(count1), 32'(occ));
    chk({tag, ".ovf1"},   32'(ovf1),   32'(exp_ovf));
    chk({tag, ".unf1"},   32'(unf1),   32'(exp_unf));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 8'h11};
    vecs[1] = '{1'b1, 1'b1, 8'h22, 1, 1'b0, 1'b0, 8'h11, 8'h22};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h22, 8'h22};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 8'h22, 8'h22};
    vecs[4] = '{1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b1, 8'h22, 8'h33};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 8'h22, 8'h33};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 8'h33, 8'h33};

    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    #2;
    chk("async_reset.count", 32'(count0), 32'd0);
    chk("async_reset.empty", 32'(empty0), 32'd1);
    applyReset();
    checkOutput("reset");

    // Hand-derived vectors: simple traffic, underflow, simultaneous rd/wr at empty.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d.count", i), 32'(count0), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.empty", i), 32'(empty0), 32'(vecs[i].exp_count == 0));
      chk($sformatf("vec%0d.ovf", i),   32'(ovf0),   32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d.unf", i),   32'(unf0),   32'(vecs[i].exp_unf));
      chk($sformatf("vec%0d.dout0", i), 32'(dout0),  32'(vecs[i].exp_d0));
      chk($sformatf("vec%0d.dout1", i), 32'(dout1),  32'(vecs[i].exp_d1));
    end

    // Fill to full, then one rejected write.
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i));
      checkOutput($sformatf("fill%0d", i));
    end
    chk("fill.full_hard", 32'(full0), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h99);
    checkOutput("fill_over");
    chk("fill_over.ovf_hard", 32'(ovf0), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("fill_idle");

    // Drain all 16 then one rejected read.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("drain%0d", i));
      chk($sformatf("drain%0d.dout_hard", i), 32'(dout0), 32'(i));
    end
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("drain_under");
    chk("drain_under.unf_hard", 32'(unf0), 32'd1);

    // Steady-state streaming at count 8 across pointer wrap.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h80 + i));
      checkOutput($sformatf("stream%0d", i));
    end
    chk("stream.count_hard", 32'(count0), 32'd8);

    // Simultaneous read/write at full.
    applyReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(8'hC0 + i));
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("full_rw");
    chk("full_rw.dout_hard", 32'(dout0), 32'hC0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("full_rw_drain%0d", i));
    end
    chk("full_rw.last_hard", 32'(dout0), 32'hAA);

    // FWFT: first word falls through without a read.
    applyReset();
    applyStimulus(1'b1, 1'b0, 8'h5A);
    checkOutput("fwft_wr");
    chk("fwft_wr.dout1_hard", 32'(dout1), 32'h5A);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("fwft_rd");
    chk("fwft_rd.empty1_hard", 32'(empty1), 32'd1);
    chk("fwft_rd.hold_hard", 32'(dout1), 32'h5A);

    // Asynchronous reset mid-operation at count 9.
    applyReset();
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i));
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h69);
    checkOutput("pre_async");
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async.count", 32'(count0), 32'd0);
    chk("async.empty", 32'(empty0), 32'd1);
    chk("async.dout0", 32'(dout0),  32'd0);
    chk("async.dout1", 32'(dout1),  32'd0);
    sb_q.delete();
    exp_d0  = 8'h00;
    exp_d1  = 8'h00;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h33);
    checkOutput("post_async_wr");
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("post_async_rd");
    chk("post_async.dout_hard", 32'(dout0), 32'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
